// File: rtl/tpu_pkg.sv
// rtl/tpu_pkg.sv - shared TPU types and width helpers
// Purpose: writeback FSM state type and address/index width helpers shared
//          by the memory, TPU and writeback modules.
package tpu_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WRITE  = 2'd1,
    FINISH = 2'd2
  } wb_state_t;

  // Address width for an image of the given pixel count (never below 1 bit).
  function automatic int calc_addr_width(input int pixels);
    return (pixels > 1) ? $clog2(pixels) : 1;
  endfunction

  // Width of an index selecting one of n units (never below 1 bit).
  function automatic int calc_index_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tpu_wb_priority_enc.sv
// rtl/tpu_wb_priority_enc.sv - lowest-set-bit priority encoder over the pending mask
// Ports:
//   mask  in   [NUM_UNITS-1:0]  pending unit mask
//   idx   out  [IDX_WIDTH-1:0]  index of the lowest set bit (0 when mask is empty)
//   valid out  1                mask has at least one bit set
module tpu_wb_priority_enc
  import tpu_pkg::*;
#(
  parameter  int NUM_UNITS = 2,
  localparam int IDX_WIDTH = calc_index_width(NUM_UNITS)
) (
  input  logic [NUM_UNITS-1:0] mask,
  output logic [IDX_WIDTH-1:0] idx,
  output logic                 valid
);

  // Scan from the top down so the lowest set bit is the last assignment.
  always_comb begin
    idx   = '0;
    valid = |mask;
    for (int i = NUM_UNITS - 1; i >= 0; i--) begin
      if (mask[i]) idx = IDX_WIDTH'(i);
    end
  end

endmodule

// File: rtl/tpu_result_writeback.sv
// rtl/tpu_result_writeback.sv - captures TPU results on done and writes them to image memory
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   done                  completion pulse; captures relu_out/dest_addr/done_array when idle
//   relu_out, dest_addr   per-unit result word and destination address
//   done_array            per-unit write enable mask
//   wr_en/wr_addr/wr_data memory write request, accepted when wr_en & wr_ready
//   wr_ready              memory accepts the current write
//   busy                  capture in progress
//   write_done            one-cycle pulse after the last accepted write
//   overrun               sticky: done arrived while busy
module tpu_result_writeback
  import tpu_pkg::*;
#(
  parameter  int DATA_WIDTH   = 16,
  parameter  int IMAGE_WIDTH  = 8,
  parameter  int IMAGE_HEIGHT = 8,
  parameter  int NUM_UNITS    = 2,
  localparam int ADDR_WIDTH   = calc_addr_width(IMAGE_WIDTH * IMAGE_HEIGHT)
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 done,
  input  logic [NUM_UNITS-1:0][DATA_WIDTH-1:0] relu_out,
  input  logic [NUM_UNITS-1:0]                 done_array,
  input  logic [NUM_UNITS-1:0][ADDR_WIDTH-1:0] dest_addr,
  output logic                                 wr_en,
  output logic [ADDR_WIDTH-1:0]                wr_addr,
  output logic [DATA_WIDTH-1:0]                wr_data,
  input  logic                                 wr_ready,
  output logic                                 busy,
  output logic                                 write_done,
  output logic                                 overrun
);

  localparam int IDX_WIDTH = calc_index_width(NUM_UNITS);

  wb_state_t                            state;
  logic [NUM_UNITS-1:0]                 pending;
  logic [NUM_UNITS-1:0][DATA_WIDTH-1:0] buf_data;
  logic [NUM_UNITS-1:0][ADDR_WIDTH-1:0] buf_addr;
  logic [IDX_WIDTH-1:0]                 cur_idx;
  logic                                 cur_valid;
  logic [NUM_UNITS-1:0]                 pending_next;

  tpu_wb_priority_enc #(
    .NUM_UNITS(NUM_UNITS)
  ) u_prio (
    .mask (pending),
    .idx  (cur_idx),
    .valid(cur_valid)
  );

  // Mask as it will look once the current write is accepted.
  assign pending_next = pending & ~(NUM_UNITS'(1) << cur_idx);

  // Write port is decoded from registered state only; idle outputs are forced to zero.
  assign wr_en      = (state == WRITE) && cur_valid;
  assign wr_addr    = wr_en ? buf_addr[cur_idx] : '0;
  assign wr_data    = wr_en ? buf_data[cur_idx] : '0;
  assign busy       = (state != IDLE);
  assign write_done = (state == FINISH);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      pending  <= '0;
      buf_data <= '0;
      buf_addr <= '0;
      overrun  <= 1'b0;
    end else begin
      // FINISH counts as busy, so a done landing on the write_done pulse is an overrun.
      if (done && (state != IDLE)) overrun <= 1'b1;

      case (state)
        IDLE: begin
          if (done) begin
            buf_data <= relu_out;
            buf_addr <= dest_addr;
            pending  <= done_array;
            state    <= (done_array != '0) ? WRITE : FINISH;
          end
        end
        WRITE: begin
          if (wr_en && wr_ready) begin
            pending <= pending_next;
            if (pending_next == '0) state <= FINISH;
          end
        end
        FINISH: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tpu_result_writeback.sv
// tb/tb_tpu_result_writeback.sv - self-checking bench for tpu_result_writeback
module tb_tpu_result_writeback;

  logic             clk = 1'b0;
  logic             reset;
  logic             done;
  logic [1:0][15:0] relu_out;
  logic [1:0]       done_array;
  logic [1:0][5:0]  dest_addr;
  logic             wr_en;
  logic [5:0]       wr_addr;
  logic [15:0]      wr_data;
  logic             wr_ready;
  logic             busy;
  logic             write_done;
  logic             overrun;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] mem [64];
  logic [5:0]  exp_a [$];
  logic [15:0] exp_d [$];

  tpu_result_writeback #(
    .DATA_WIDTH(16), .IMAGE_WIDTH(8), .IMAGE_HEIGHT(8), .NUM_UNITS(2)
  ) dut (
    .clk(clk), .reset(reset), .done(done), .relu_out(relu_out),
    .done_array(done_array), .dest_addr(dest_addr), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .busy(busy), .write_done(write_done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  typedef struct {
    logic [15:0] d0, d1;
    logic [5:0]  a0, a1;
    logic [1:0]  mask;
    int          stall;
    int          n_exp;
    logic [5:0]  ea0, ea1;
    logic [15:0] ed0, ed1;
    int          exp_done;
  } vec_t;

  vec_t vecs [6];

  function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    done  = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Expected writes are in exp_a/exp_d. Cycle 0 is the cycle carrying done.
  task automatic run_txn(input logic [1:0][15:0] d, input logic [1:0][5:0] a,
                         input logic [1:0] m, input int stall, input bit rnd_ready,
                         input int again_cyc, input int exp_done);
    int c;
    int last_acc;
    bit seen;
    c = 0; last_acc = 0; seen = 0;
    relu_out = d; dest_addr = a; done_array = m; done = 1'b1; wr_ready = 1'b1;
    while (!seen && c < 200) begin
      @(negedge clk);
      c++;
      done = (c == again_cyc);
      if (c == again_cyc) relu_out = {16'd1, 16'd1};
      chk("busy_during_txn", busy, 1);
      if (c == 1 && m != 2'b00) chk("first_wr_en", wr_en, 1);
      if (wr_en) begin
        if (exp_a.size() == 0) chk("unexpected_write", 1, 0);
        else begin
          chk("wr_addr", wr_addr, exp_a[0]);
          chk("wr_data", wr_data, exp_d[0]);
        end
      end else begin
        chk("idle_wr_addr", wr_addr, 0);
        chk("idle_wr_data", wr_data, 0);
      end
      if (write_done) begin
        seen = 1;
        chk("writes_left_at_done", exp_a.size(), 0);
        chk("done_after_last_write", c, last_acc + 1);
        if (exp_done >= 0) chk("done_cycle", c, exp_done);
      end
      wr_ready = rnd_ready ? 1'($urandom_range(0, 1)) : (c > stall);
      if (wr_en && wr_ready) begin
        mem[wr_addr] = wr_data;
        last_acc = c;
        if (exp_a.size() != 0) begin
          void'(exp_a.pop_front());
          void'(exp_d.pop_front());
        end
      end
    end
    if (!seen) chk("write_done_timeout", 0, 1);
    @(negedge clk);
    done = 1'b0;
    chk("write_done_one_cycle", write_done, 0);
    chk("busy_after_done", busy, 0);
    wr_ready = 1'b1;
  endtask

  task automatic clear_exp();
    exp_a.delete();
    exp_d.delete();
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = '0;
    relu_out = '0; dest_addr = '0; done_array = '0; wr_ready = 1'b1;
    do_reset();

    chk("reset_wr_en", wr_en, 0);
    chk("reset_wr_addr", wr_addr, 0);
    chk("reset_wr_data", wr_data, 0);
    chk("reset_busy", busy, 0);
    chk("reset_write_done", write_done, 0);
    chk("reset_overrun", overrun, 0);

    //         d0       d1       a0  a1  mask   st n  ea0 ea1 ed0      ed1      done
    vecs[0] = '{16'd5,   16'd9,   10, 20, 2'b11, 0, 2, 10, 20, 16'd5,   16'd9,   3};
    vecs[1] = '{16'hAAAA,16'd7,   40, 3,  2'b10, 0, 1, 3,  0,  16'd7,   16'd0,   2};
    vecs[2] = '{16'd5,   16'd9,   10, 20, 2'b11, 3, 2, 10, 20, 16'd5,   16'd9,   6};
    vecs[3] = '{16'd1,   16'd2,   30, 31, 2'b00, 0, 0, 0,  0,  16'd0,   16'd0,   1};
    vecs[4] = '{16'h11,  16'h22,  5,  5,  2'b11, 0, 2, 5,  5,  16'h11,  16'h22,  3};
    vecs[5] = '{16'hFFFF,16'h8000,63, 0,  2'b01, 2, 1, 63, 0,  16'hFFFF,16'd0,   4};

    for (int v = 0; v < 6; v++) begin
      clear_exp();
      if (vecs[v].n_exp >= 1) begin exp_a.push_back(vecs[v].ea0); exp_d.push_back(vecs[v].ed0); end
      if (vecs[v].n_exp >= 2) begin exp_a.push_back(vecs[v].ea1); exp_d.push_back(vecs[v].ed1); end
      run_txn({vecs[v].d1, vecs[v].d0}, {vecs[v].a1, vecs[v].a0}, vecs[v].mask,
              vecs[v].stall, 1'b0, 0, vecs[v].exp_done);
      if (v == 0) begin
        chk("mem10_basic", mem[10], 16'd5);
        chk("mem20_basic", mem[20], 16'd9);
      end
      if (v == 1) chk("mem40_untouched", mem[40], 16'd0);
      if (v == 4) chk("mem5_dup_later_wins", mem[5], 16'h22);
    end

    // Randomized captures against the ordered-write model.
    for (int t = 0; t < 40; t++) begin
      logic [1:0][15:0] rd;
      logic [1:0][5:0]  ra;
      logic [1:0]       rm;
      rd[0] = 16'($urandom); rd[1] = 16'($urandom);
      ra[0] = 6'($urandom_range(0, 63)); ra[1] = 6'($urandom_range(0, 63));
      rm    = 2'($urandom_range(0, 3));
      clear_exp();
      for (int u = 0; u < 2; u++) if (rm[u]) begin exp_a.push_back(ra[u]); exp_d.push_back(rd[u]); end
      run_txn(rd, ra, rm, $urandom_range(0, 3), 1'($urandom_range(0, 1)), 0, -1);
    end
    chk("no_overrun_after_random", overrun, 0);

    // Second done one cycle after capture: ignored, overrun sticky.
    mem[10] = '0; mem[20] = '0;
    clear_exp();
    exp_a.push_back(10); exp_d.push_back(5); exp_a.push_back(20); exp_d.push_back(9);
    run_txn({16'd9, 16'd5}, {6'd20, 6'd10}, 2'b11, 0, 1'b0, 1, 3);
    chk("overrun_set", overrun, 1);
    chk("mem10_orig", mem[10], 16'd5);
    chk("mem20_orig", mem[20], 16'd9);
    clear_exp();
    exp_a.push_back(3); exp_d.push_back(7);
    run_txn({16'd7, 16'd0}, {6'd3, 6'd0}, 2'b10, 0, 1'b0, 0, 2);
    chk("overrun_sticky", overrun, 1);

    // done coinciding with the write_done pulse is an overrun and not a capture.
    do_reset();
    chk("overrun_cleared", overrun, 0);
    clear_exp();
    exp_a.push_back(7); exp_d.push_back(16'h33);
    run_txn({16'd0, 16'h33}, {6'd0, 6'd7}, 2'b01, 0, 1'b0, 2, 2);
    chk("overrun_on_finish", overrun, 1);
    repeat (2) begin
      @(negedge clk);
      chk("no_recapture_wr_en", wr_en, 0);
      chk("no_recapture_busy", busy, 0);
    end

    // Reset in the middle of a stalled write.
    relu_out = {16'd9, 16'd5}; dest_addr = {6'd20, 6'd10}; done_array = 2'b11;
    wr_ready = 1'b0; done = 1'b1;
    @(negedge clk); done = 1'b0;
    chk("midrst_wr_en_n1", wr_en, 1);
    @(negedge clk);
    chk("midrst_wr_en_n2", wr_en, 1);
    reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    chk("midrst_wr_en_n3", wr_en, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_overrun", overrun, 0);
    chk("midrst_write_done", write_done, 0);
    wr_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("midrst_quiet_done", write_done, 0);
      chk("midrst_quiet_wr_en", wr_en, 0);
    end
    clear_exp();
    exp_a.push_back(10); exp_d.push_back(5); exp_a.push_back(20); exp_d.push_back(9);
    run_txn({16'd9, 16'd5}, {6'd20, 6'd10}, 2'b11, 0, 1'b0, 0, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tpu_result_writeback.md
Name: tpu_result_writeback

Overview:
- Write-side counterpart of the TPU's memory read path: when the tensor processing unit signals done, this block captures the per-unit ReLU results.
- It then writes each enabled result into image memory through a single write port, lowest unit index first.
- It replaces hierarchical testbench pokes and manual output sampling with a real write interface that honours backpressure.
- It sits between tensor_processing_unit outputs and the memory write port.

Parameters:
- DATA_WIDTH, 16, width of one result word.
- IMAGE_WIDTH, 8, image width in pixels.
- IMAGE_HEIGHT, 8, image height in pixels.
- NUM_UNITS, 2, number of parallel compute units/results.
- ADDR_WIDTH (localparam), $clog2(IMAGE_WIDTH*IMAGE_HEIGHT), memory address width.

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high reset
- done  in  1  TPU completion pulse; capture trigger
- relu_out  in  [NUM_UNITS-1:0][DATA_WIDTH-1:0]  per-unit results
- done_array  in  [NUM_UNITS-1:0]  per-unit enable mask; 1 = write this unit's result
- dest_addr  in  [NUM_UNITS-1:0][ADDR_WIDTH-1:0]  per-unit destination address
- wr_en  out  1  memory write request
- wr_addr  out  ADDR_WIDTH  write address
- wr_data  out  DATA_WIDTH  write data
- wr_ready  in  1  memory accepts the write this cycle when wr_en & wr_ready
- busy  out  1  high while a capture is pending
- write_done  out  1  one-cycle pulse after the last write is accepted
- overrun  out  1  sticky; done arrived while busy

Behaviour:
- Reset (sync, active-high) values: state=IDLE, pending mask=0, buffers=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, write_done=0, overrun=0.
- States: IDLE, WRITE, FINISH.
- IDLE:
  - done=1 at edge N captures relu_out, dest_addr and done_array into internal registers.
  - Mask != 0 -> WRITE; mask == 0 -> FINISH.
- WRITE:
  - k = lowest set bit of pending mask.
  - wr_en=1, wr_addr=buf_addr[k], wr_data=buf_data[k]; these are decoded combinationally from registered state only, with no input-to-output path.
  - On wr_en & wr_ready, clear pending[k].
  - When the cleared bit was the last one -> FINISH.
  - With wr_ready=0, outputs hold stable and the mask is unchanged.
- FINISH: write_done=1 for exactly one cycle -> IDLE.
- busy=1 in WRITE and FINISH.
- Latency: wr_en first high in cycle N+1. M enabled units with wr_ready held high: writes in cycles N+1..N+M, write_done in N+M+1, IDLE accepts a new done in N+M+2.
- Empty mask: write_done in N+1, no wr_en.
- done while busy: ignored (no recapture, buffers untouched); overrun set in the next cycle and held until reset.
- done in the same cycle as the FINISH pulse counts as busy and is an overrun.
- Data is written unmodified (no saturation or truncation); addresses are used as given, with no wrap arithmetic.
- Duplicate dest_addr values are both written, in ascending unit order, so the later unit wins.
- Reset mid-operation: abandon pending writes, no write_done pulse, wr_en low in the cycle after the reset edge.
- wr_addr and wr_data are 0 whenever wr_en=0.

Decomposition:
- Shared package tpu_pkg:
  - typedef enum logic [1:0] wb_state_t {IDLE, WRITE, FINISH}
  - constant/function for address width from IMAGE_WIDTH*IMAGE_HEIGHT, shared with the memory and TPU modules.
- One sub-module: tpu_wb_priority_enc, parameterised NUM_UNITS.
  - Combinational lowest-set-bit index plus valid flag over the pending mask.
  - Instantiated once.

Test Plan:
- Basic pair: NUM_UNITS=2, relu_out[0]=5, relu_out[1]=9, dest_addr={0:10, 1:20}, done_array=2'b11, wr_ready=1, done pulse at N.
  - Writes (10,5) at N+1 and (20,9) at N+2; write_done at N+3; memory[10]=5, memory[20]=9.
- Masked unit: done_array=2'b10, relu_out[1]=7, dest_addr[1]=3.
  - Single write (3,7) at N+1; write_done at N+2; unit 0 address untouched.
- Backpressure: as basic pair, with wr_ready low for cycles N+1..N+3.
  - (10,5) held stable for 3 cycles and accepted at N+4; (20,9) at N+5; write_done at N+6.
- Empty mask and overrun:
  - done_array=0 -> no wr_en, write_done at N+1.
  - Then a basic-pair capture, with a second done at N+1 carrying relu_out={1,1}: original values 5/9 written, overrun=1 and sticky.
- Reset mid-write: wr_ready=0, reset asserted at N+2.
  - wr_en=0 from N+3, no write_done, overrun=0, busy=0.
  - A subsequent done operates normally.
